// File: rtl/pipelined_register_file.sv
// ============================================================================
// pipelined_register_file: 2R/1W register file with pending-write scoreboard;
// optional REGFILE_BYPASS_EN forwards same-cycle writes. Rev 1.0
// ============================================================================
`default_nettype none

module pipelined_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  wrEnable,
   input  logic [ADDR_WIDTH-1:0] wrReg,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic [ADDR_WIDTH-1:0] rdReg1,
   input  logic [ADDR_WIDTH-1:0] rdReg2,
   output logic [DATA_WIDTH-1:0] rdData1,
   output logic [DATA_WIDTH-1:0] rdData2,
   input  logic                  issueValid,
   input  logic [ADDR_WIDTH-1:0] issueReg,
   output logic                  rdBusy1,
   output logic                  rdBusy2,
   output logic [ADDR_WIDTH:0]   busyCount
);

   localparam int                  DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;
   localparam bit                  HARD_ZERO = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] regfile_q [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic [ADDR_WIDTH:0]   busy_count_q;
   logic [ADDR_WIDTH:0]   busy_count_d;
   logic                  wr_allowed;
   logic                  issue_allowed;

   assign wr_allowed    = wrEnable   && !(HARD_ZERO && (wrReg    == ZERO_IDX));
   assign issue_allowed = issueValid && !(HARD_ZERO && (issueReg == ZERO_IDX));

   // Set is applied after clear so a new producer supersedes the retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wrEnable) begin
         busy_d[wrReg] = 1'b0;
      end
      if (issue_allowed) begin
         busy_d[issueReg] = 1'b1;
      end
      busy_count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            regfile_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         if (wr_allowed) begin
            regfile_q[wrReg] <= wrData;
         end
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busyCount = busy_count_q;

   always_comb begin
      rdData1 = regfile_q[rdReg1];
      rdBusy1 = busy_q[rdReg1];
`ifdef REGFILE_BYPASS_EN
      if (wrEnable && (wrReg == rdReg1)) begin
         rdData1 = wrData;
         if (!(issueValid && (issueReg == rdReg1))) begin
            rdBusy1 = 1'b0;
         end
      end
`endif
      if (HARD_ZERO && (rdReg1 == ZERO_IDX)) begin
         rdData1 = '0;
      end
   end

   always_comb begin
      rdData2 = regfile_q[rdReg2];
      rdBusy2 = busy_q[rdReg2];
`ifdef REGFILE_BYPASS_EN
      if (wrEnable && (wrReg == rdReg2)) begin
         rdData2 = wrData;
         if (!(issueValid && (issueReg == rdReg2))) begin
            rdBusy2 = 1'b0;
         end
      end
`endif
      if (HARD_ZERO && (rdReg2 == ZERO_IDX)) begin
         rdData2 = '0;
      end
   end

endmodule

`default_nettype wire
